// File: rtl/cell_bist_ctrl.sv
// cell_bist_ctrl: LFSR pattern source and MISR signature checker for a combinational CUT.
// Defining CELL_BIST_PATCNT_EN adds the PATCNT output (patterns applied so far).
module cell_bist_ctrl #(
  parameter int          WIDTH  = 4,
  parameter int          OWIDTH = 2,
  parameter int          NPAT   = 255,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              START,
  output logic [WIDTH-1:0]  PAT,
  input  logic [OWIDTH-1:0] RSP,
  input  logic [15:0]       GOLDEN,
  output logic              BUSY,
  output logic              DONE,
  output logic [15:0]       SIG,
  output logic              PASS
`ifdef CELL_BIST_PATCNT_EN
  ,
  output logic [15:0]       PATCNT
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [15:0] LAST = 16'(NPAT - 1);

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] misr_q, misr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] rsp_ext;

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
  function automatic logic [15:0] step(input logic [15:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction

  // Zero-extend the CUT response to the MISR width
  always_comb begin
    rsp_ext = '0;
    rsp_ext[OWIDTH-1:0] = RSP;
  end

  // State, LFSR, MISR and pattern counter registers with synchronous reset
  always_ff @(posedge CK) begin
    if (!RN) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: start or restart re-inits, RUN steps both registers once per pattern
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_RUN;
          lfsr_d  = SEED;
          misr_d  = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        misr_d = step(misr_q) ^ rsp_ext;
        lfsr_d = step(lfsr_q);
        cnt_d  = cnt_q + 16'd1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    BUSY = (state_q == S_RUN);
    DONE = (state_q == S_DONE);
    PAT  = BUSY ? lfsr_q[WIDTH-1:0] : '0;
    SIG  = (state_q == S_IDLE) ? '0 : misr_q;
    PASS = DONE && (misr_q == GOLDEN);
  end

`ifdef CELL_BIST_PATCNT_EN
  assign PATCNT = cnt_q;
`endif

endmodule

// File: tb/tb_cell_bist_ctrl.sv
// tb_cell_bist_ctrl: three controllers (NPAT 3/255/2) against a sequence-level model.
// Literal checks pin the LFSR sequence, signatures and mid-run reset behaviour.
module tb_cell_bist_ctrl;

  logic CK = 1'b0;
  logic RN = 1'b0;
  logic START = 1'b0;
  always #5 CK = ~CK;

  logic [2:0][15:0] gold;
  logic [2:0][3:0]  pat;
  logic [2:0][1:0]  rsp;
  logic [2:0]       busy, done, pass;
  logic [2:0][15:0] sig;
`ifdef CELL_BIST_PATCNT_EN
  logic [2:0][15:0] pcnt;
`endif

  // CUTs: u0 and u2 pass PAT[1:0] through, u1 is tied to zero
  assign rsp[0] = pat[0][1:0];
  assign rsp[1] = 2'b00;
  assign rsp[2] = pat[2][1:0];

  cell_bist_ctrl #(.WIDTH(4), .OWIDTH(2), .NPAT(3), .SEED(16'hACE1)) u0 (
    .CK(CK), .RN(RN), .START(START), .PAT(pat[0]), .RSP(rsp[0]),
    .GOLDEN(gold[0]), .BUSY(busy[0]), .DONE(done[0]), .SIG(sig[0]),
    .PASS(pass[0])
`ifdef CELL_BIST_PATCNT_EN
    , .PATCNT(pcnt[0])
`endif
  );

  cell_bist_ctrl #(.WIDTH(4), .OWIDTH(2), .NPAT(255), .SEED(16'hACE1)) u1 (
    .CK(CK), .RN(RN), .START(START), .PAT(pat[1]), .RSP(rsp[1]),
    .GOLDEN(gold[1]), .BUSY(busy[1]), .DONE(done[1]), .SIG(sig[1]),
    .PASS(pass[1])
`ifdef CELL_BIST_PATCNT_EN
    , .PATCNT(pcnt[1])
`endif
  );

  cell_bist_ctrl #(.WIDTH(4), .OWIDTH(2), .NPAT(2), .SEED(16'hACE1)) u2 (
    .CK(CK), .RN(RN), .START(START), .PAT(pat[2]), .RSP(rsp[2]),
    .GOLDEN(gold[2]), .BUSY(busy[2]), .DONE(done[2]), .SIG(sig[2]),
    .PASS(pass[2])
`ifdef CELL_BIST_PATCNT_EN
    , .PATCNT(pcnt[2])
`endif
  );

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {^(x & 16'h002D), x[15:1]};
  endfunction

  function automatic int npat_of(input int k);
    return (k == 0) ? 3 : ((k == 1) ? 255 : 2);
  endfunction

  function automatic logic [1:0] cut_of(input int k, input logic [15:0] p);
    return (k == 1) ? 2'b00 : p[1:0];
  endfunction

  // Pattern i of any run is the seed advanced i times
  logic [15:0] seq [256];
  initial begin
    seq[0] = 16'hACE1;
    for (int i = 1; i < 256; i++) seq[i] = lfsr_next(seq[i-1]);
  end

  // Model: mode 0 idle, 1 run, 2 done; n = patterns applied in this run
  int          mmode [3];
  int          mn    [3];
  logic [15:0] mmisr [3];

  always @(posedge CK) begin
    for (int k = 0; k < 3; k++) begin
      if (!RN) begin
        mmode[k] = 0;
        mn[k] = 0;
        mmisr[k] = 16'h0;
      end else if (mmode[k] == 1) begin
        mmisr[k] = lfsr_next(mmisr[k]) ^ {14'b0, cut_of(k, seq[mn[k]])};
        mn[k] = mn[k] + 1;
        if (mn[k] == npat_of(k)) mmode[k] = 2;
      end else if (START) begin
        mmode[k] = 1;
        mn[k] = 0;
        mmisr[k] = 16'h0;
      end
    end
  end

  // Per-cycle comparison of every instance against the model
  always @(negedge CK) begin
    if (cmp_en) begin
      for (int k = 0; k < 3; k++) begin
        logic [15:0] ep;
        ep = (mmode[k] == 1) ? {12'h0, seq[mn[k]][3:0]} : 16'h0;
        chk($sformatf("busy%0d", k), {15'h0, busy[k]}, {15'h0, mmode[k] == 1});
        chk($sformatf("done%0d", k), {15'h0, done[k]}, {15'h0, mmode[k] == 2});
        chk($sformatf("pat%0d", k), {12'h0, pat[k]}, ep);
        chk($sformatf("sig%0d", k), sig[k], (mmode[k] == 0) ? 16'h0 : mmisr[k]);
        chk($sformatf("pass%0d", k), {15'h0, pass[k]},
            {15'h0, (mmode[k] == 2) && (mmisr[k] == gold[k])});
`ifdef CELL_BIST_PATCNT_EN
        chk($sformatf("patcnt%0d", k), pcnt[k], 16'(mn[k]));
`endif
      end
    end
  end

  task automatic tick();
    @(negedge CK);
    #1;
    cyc++;
  endtask

  initial begin
    int t0;
    gold[0] = 16'h4000;
    gold[1] = 16'h0000;
    gold[2] = 16'h8000;
    repeat (2) tick();
    cmp_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", {15'h0, busy[k]}, 16'h0);
      chk("rst_done", {15'h0, done[k]}, 16'h0);
      chk("rst_sig", sig[k], 16'h0);
      chk("rst_pat", {12'h0, pat[k]}, 16'h0);
    end

    RN = 1'b1;
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("seq_pat0", {12'h0, pat[0]}, 16'h0001);
    tick();
    chk("seq_pat1", {12'h0, pat[0]}, 16'h0000);
    tick();
    chk("seq_pat2", {12'h0, pat[0]}, 16'h0008);
    chk("pt2_done", {15'h0, done[2]}, 16'h0001);
    chk("pt2_sig", sig[2], 16'h8000);
    chk("pt2_pass", {15'h0, pass[2]}, 16'h0001);
    tick();
    chk("seq_done", {15'h0, done[0]}, 16'h0001);
    chk("seq_busy", {15'h0, busy[0]}, 16'h0000);
    chk("seq_sig", sig[0], 16'h4000);
    chk("seq_pass", {15'h0, pass[0]}, 16'h0001);
    chk("long_busy", {15'h0, busy[1]}, 16'h0001);

    RN = 1'b0;
    tick();
    RN = 1'b1;
    chk("mid_busy", {15'h0, busy[1]}, 16'h0);
    chk("mid_done", {15'h0, done[1]}, 16'h0);
    chk("mid_sig", sig[1], 16'h0);
    chk("mid_pat", {12'h0, pat[1]}, 16'h0);
    chk("mid_done0", {15'h0, done[0]}, 16'h0);

    START = 1'b1;
    tick();
    START = 1'b0;
    t0 = cyc;
    chk("re_pat0", {12'h0, pat[0]}, 16'h0001);
    chk("re_pat1", {12'h0, pat[1]}, 16'h0001);
    repeat (3) tick();
    chk("u0_done", {15'h0, done[0]}, 16'h0001);

    START = 1'b1;
    tick();
    START = 1'b0;
    chk("rs_busy", {15'h0, busy[0]}, 16'h0001);
    chk("rs_pass", {15'h0, pass[0]}, 16'h0000);
    chk("rs_sig", sig[0], 16'h0000);
    repeat (3) tick();

    START = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
`ifdef CELL_BIST_PATCNT_EN
      chk("hold_patcnt", pcnt[0], 16'(i < 3 ? i : 3));
`endif
    end
    START = 1'b0;
    chk("hold_done", {15'h0, done[0]}, 16'h0001);

    while (done[1] !== 1'b1 && cyc - t0 < 400) tick();
    chk("long_len", 16'(cyc - t0 + 1), 16'd256);
    chk("long_sig", sig[1], 16'h0000);
    chk("long_pass", {15'h0, pass[1]}, 16'h0001);
    gold[1] = 16'h0001;
    #1;
    chk("gold_pass", {15'h0, pass[1]}, 16'h0000);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
